// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_REQ requesters and
// sequences each single-byte transaction through IDLE -> WAIT -> RESP.
module i2c_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [7*NUM_REQ-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]     req_rwb,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic                   err,
   output logic [7:0]             rdata,
   output logic                   busy,
   output logic                   m_enable,
   output logic [6:0]             m_address,
   output logic [7:0]             m_data_in,
   output logic                   m_r_wb,
   input  logic                   m_done,
   input  logic                   m_nack,
   input  logic [7:0]             m_rdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t               state_reg, state_next;
   logic [PTR_W-1:0]     ptr_reg, ptr_next;
   logic [PTR_W-1:0]     idx_reg, idx_next;
   logic [TO_W-1:0]      cnt_reg, cnt_next;
   logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]   done_reg, done_next;
   logic                 err_reg, err_next;
   logic [7:0]           rdata_reg, rdata_next;
   logic                 busy_reg, busy_next;
   logic                 m_enable_reg, m_enable_next;
   logic [6:0]           m_address_reg, m_address_next;
   logic [7:0]           m_data_in_reg, m_data_in_next;
   logic                 m_r_wb_reg, m_r_wb_next;

   logic [6:0]           addr_slice  [NUM_REQ];
   logic [7:0]           wdata_slice [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_slice[gi]  = req_addr[7*gi +: 7];
      assign wdata_slice[gi] = req_wdata[8*gi +: 8];
   end

   // Round-robin scan starting at ptr_reg; first set request wins.
   logic                 sel_found;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W:0]       scan_sum;
   logic [PTR_W-1:0]     scan_idx;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(off);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ))
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         scan_idx = scan_sum[PTR_W-1:0];
         if (!sel_found && req[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      idx_next       = idx_reg;
      cnt_next       = cnt_reg;
      gnt_next       = gnt_reg;
      done_next      = '0;
      err_next       = err_reg;
      rdata_next     = rdata_reg;
      busy_next      = busy_reg;
      m_enable_next  = m_enable_reg;
      m_address_next = m_address_reg;
      m_data_in_next = m_data_in_reg;
      m_r_wb_next    = m_r_wb_reg;

      case (state_reg)
         ST_IDLE: begin
            if (sel_found) begin
               for (int i = 0; i < NUM_REQ; i++)
                  gnt_next[i] = (sel_idx == PTR_W'(i));
               idx_next       = sel_idx;
               m_enable_next  = 1'b1;
               m_address_next = addr_slice[sel_idx];
               m_data_in_next = wdata_slice[sel_idx];
               m_r_wb_next    = req_rwb[sel_idx];
               cnt_next       = '0;
               busy_next      = 1'b1;
               state_next     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (m_done || (cnt_reg == TO_W'(TIMEOUT-1))) begin
               // Completion beats timeout when both land in the same cycle.
               err_next      = m_done ? m_nack : 1'b1;
               rdata_next    = (m_done && m_r_wb_reg) ? m_rdata : 8'h00;
               done_next     = gnt_reg;
               gnt_next      = '0;
               m_enable_next = 1'b0;
               cnt_next      = '0;
               ptr_next      = (idx_reg == PTR_W'(NUM_REQ-1)) ? '0 : idx_reg + PTR_W'(1);
               state_next    = ST_RESP;
            end else begin
               cnt_next = cnt_reg + TO_W'(1);
            end
         end
         ST_RESP: begin
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         idx_reg       <= '0;
         cnt_reg       <= '0;
         gnt_reg       <= '0;
         done_reg      <= '0;
         err_reg       <= 1'b0;
         rdata_reg     <= '0;
         busy_reg      <= 1'b0;
         m_enable_reg  <= 1'b0;
         m_address_reg <= '0;
         m_data_in_reg <= '0;
         m_r_wb_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         idx_reg       <= idx_next;
         cnt_reg       <= cnt_next;
         gnt_reg       <= gnt_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         rdata_reg     <= rdata_next;
         busy_reg      <= busy_next;
         m_enable_reg  <= m_enable_next;
         m_address_reg <= m_address_next;
         m_data_in_reg <= m_data_in_next;
         m_r_wb_reg    <= m_r_wb_next;
      end
   end

   assign gnt       = gnt_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign rdata     = rdata_reg;
   assign busy      = busy_reg;
   assign m_enable  = m_enable_reg;
   assign m_address = m_address_reg;
   assign m_data_in = m_data_in_reg;
   assign m_r_wb    = m_r_wb_reg;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: tests queue expected grants and
// completions, a negedge monitor pops and compares them as the DUT produces them.
module tb_i2c_master_arbiter;

   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 20;
   localparam int TO_W    = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [7*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]   req_rwb;
   logic [8*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]   gnt, done;
   logic                 err, busy, m_enable, m_r_wb;
   logic [7:0]           rdata, m_data_in, m_rdata;
   logic [6:0]           m_address;
   logic                 m_done, m_nack;

   logic [6:0] cfg_addr  [NUM_REQ];
   logic [7:0] cfg_wdata [NUM_REQ];
   logic       cfg_rwb   [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cfg
      assign req_addr[7*gi +: 7]  = cfg_addr[gi];
      assign req_wdata[8*gi +: 8] = cfg_wdata[gi];
      assign req_rwb[gi]          = cfg_rwb[gi];
   end

   i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rwb(req_rwb),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .busy(busy), .m_enable(m_enable), .m_address(m_address), .m_data_in(m_data_in),
      .m_r_wb(m_r_wb), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_REQ-1:0] gnt;
      logic [6:0]         addr;
      logic [7:0]         wdata;
      logic               rwb;
   } gnt_exp_t;

   typedef struct {
      logic [NUM_REQ-1:0] done;
      logic               err;
      logic [7:0]         rdata;
      bit                 lat_chk;
   } done_exp_t;

   gnt_exp_t  gnt_q [$];
   done_exp_t done_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Responder standing in for i2c_master
   bit        resp_en    = 1'b1;
   int        resp_delay = 2;
   logic      resp_nack  = 1'b0;
   logic [7:0] resp_rdata = 8'h00;

   initial begin
      bit seen;
      seen    = 1'b0;
      m_done  = 1'b0;
      m_nack  = 1'b0;
      m_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!m_enable) seen = 1'b0;
         else if (!seen) begin
            seen = 1'b1;
            if (resp_en) begin
               repeat (resp_delay) @(negedge clk);
               m_done  = 1'b1;
               m_nack  = resp_nack;
               m_rdata = resp_rdata;
               @(negedge clk);
               m_done  = 1'b0;
               m_nack  = 1'b0;
               m_rdata = 8'h00;
            end
         end
      end
   end

   // Monitor: compares grants and completions against the queues
   initial begin
      logic [NUM_REQ-1:0] prev_gnt;
      int cyc, g_cyc, low_run;
      gnt_exp_t  ge;
      done_exp_t de;
      prev_gnt = '0; cyc = 0; g_cyc = 0; low_run = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_gnt = '0;
            low_run  = 0;
         end else begin
            cyc++;
            if (gnt != '0 && prev_gnt == '0) begin
               if (gnt_q.size() == 0) check_eq("gnt_unexpected", 32'(gnt), 32'h0);
               else begin
                  ge = gnt_q.pop_front();
                  check_eq("gnt", 32'(gnt), 32'(ge.gnt));
                  check_eq("m_address", 32'(m_address), 32'(ge.addr));
                  check_eq("m_data_in", 32'(m_data_in), 32'(ge.wdata));
                  check_eq("m_r_wb", 32'(m_r_wb), 32'(ge.rwb));
                  check_eq("m_enable", 32'(m_enable), 32'h1);
                  check_eq("busy_wait", 32'(busy), 32'h1);
                  check_eq("en_gap_min", 32'(low_run >= 2), 32'h1);
               end
               g_cyc = cyc;
            end
            if (done != '0) begin
               $display("txn done=%b err=%b rdata=%h gnt=%b m_enable=%b", done, err, rdata, gnt, m_enable);
               if (done_q.size() == 0) check_eq("done_unexpected", 32'(done), 32'h0);
               else begin
                  de = done_q.pop_front();
                  check_eq("done", 32'(done), 32'(de.done));
                  check_eq("err", 32'(err), 32'(de.err));
                  check_eq("rdata", 32'(rdata), 32'(de.rdata));
                  check_eq("gnt_in_resp", 32'(gnt), 32'h0);
                  check_eq("m_enable_in_resp", 32'(m_enable), 32'h0);
                  if (de.lat_chk) check_eq("timeout_latency", 32'(cyc - g_cyc), 32'(TIMEOUT));
               end
            end
            low_run  = m_enable ? 0 : low_run + 1;
            prev_gnt = gnt;
         end
      end
   end

   task automatic push_gnt(input int idx);
      gnt_exp_t ge;
      ge.gnt   = NUM_REQ'(1) << idx;
      ge.addr  = cfg_addr[idx];
      ge.wdata = cfg_wdata[idx];
      ge.rwb   = cfg_rwb[idx];
      gnt_q.push_back(ge);
   endtask

   task automatic push_txn(input int idx, input logic e, input logic [7:0] rd, input bit lat);
      done_exp_t de;
      push_gnt(idx);
      de.done    = NUM_REQ'(1) << idx;
      de.err     = e;
      de.rdata   = rd;
      de.lat_chk = lat;
      done_q.push_back(de);
   endtask

   // Wait for n completions; requesters drop req after their own done unless held.
   task automatic run_txns(input int n, input bit hold, input int budget);
      int got, cyc;
      got = 0; cyc = 0;
      while (got < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done != '0) begin
            got++;
            if (!hold) req = req & ~done;
         end
      end
      if (hold) req = '0;
      check_eq("run_budget", 32'(got), 32'(n));
   endtask

   initial begin
      req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cfg_addr[i]  = 7'h10 + 7'(i);
         cfg_wdata[i] = 8'hC0 + 8'(i);
         cfg_rwb[i]   = 1'b0;
      end
      reset = 1'b0;
      #3;
      check_eq("rst_gnt", 32'(gnt), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
      check_eq("rst_busy_en", 32'({busy, m_enable, err, m_r_wb}), 32'h0);
      check_eq("rst_data", 32'({rdata, m_address, m_data_in}), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Simultaneous requests from reset: 0 then 2
      push_txn(0, 1'b0, 8'h00, 1'b0);
      push_txn(2, 1'b0, 8'h00, 1'b0);
      req = 4'b0101;
      run_txns(2, 1'b0, 100);
      repeat (3) @(negedge clk);

      // Single write with latency check
      cfg_addr[1] = 7'h2D; cfg_wdata[1] = 8'h67; cfg_rwb[1] = 1'b0;
      resp_rdata = 8'h33;
      push_txn(1, 1'b0, 8'h00, 1'b0);
      req = 4'b0010;
      check_eq("pre_gnt", 32'(gnt), 32'h0);
      @(posedge clk); #1;
      check_eq("gnt_latency", 32'(gnt), 32'h2);
      check_eq("en_latency", 32'(m_enable), 32'h1);
      run_txns(1, 1'b0, 100);
      repeat (3) @(negedge clk);

      // Read
      cfg_rwb[0] = 1'b1;
      resp_rdata = 8'hA5;
      push_txn(0, 1'b0, 8'hA5, 1'b0);
      req = 4'b0001;
      run_txns(1, 1'b0, 100);
      repeat (3) @(negedge clk);

      // Fairness with all requests held; pointer now sits at 1
      resp_rdata = 8'h5A;
      for (int k = 0; k < 8; k++) begin
         int idx;
         idx = (1 + k) % NUM_REQ;
         push_txn(idx, 1'b0, (idx == 0) ? 8'h5A : 8'h00, 1'b0);
      end
      req = 4'b1111;
      run_txns(8, 1'b1, 400);
      repeat (3) @(negedge clk);

      // NACK on a write
      resp_nack = 1'b1; resp_rdata = 8'h77;
      push_txn(2, 1'b1, 8'h00, 1'b0);
      req = 4'b0100;
      run_txns(1, 1'b0, 100);
      resp_nack = 1'b0;
      repeat (3) @(negedge clk);

      // Timeout: master never answers
      resp_en = 1'b0;
      push_txn(3, 1'b1, 8'h00, 1'b1);
      req = 4'b1000;
      run_txns(1, 1'b0, TIMEOUT + 20);
      repeat (3) @(negedge clk);

      // m_done lands exactly on the timeout cycle: completion wins
      resp_en = 1'b1; resp_delay = TIMEOUT - 1; resp_rdata = 8'hC3;
      push_txn(0, 1'b0, 8'hC3, 1'b1);
      req = 4'b0001;
      run_txns(1, 1'b0, TIMEOUT + 20);
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of WAIT
      resp_en = 1'b0; resp_delay = 1;
      push_gnt(2);
      req = 4'b0100;
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("async_gnt", 32'(gnt), 32'h0);
      check_eq("async_en_busy", 32'({m_enable, busy}), 32'h0);
      check_eq("async_done", 32'(done), 32'h0);
      repeat (2) @(negedge clk);
      req = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Pointer back at 0 after reset
      resp_en = 1'b1;
      cfg_rwb[0] = 1'b0;
      push_txn(0, 1'b0, 8'h00, 1'b0);
      push_txn(3, 1'b0, 8'h00, 1'b0);
      req = 4'b1001;
      run_txns(2, 1'b0, 100);
      repeat (5) @(negedge clk);

      check_eq("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
      check_eq("done_q_empty", 32'(done_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
